// File: rtl/gate_response_checker.sv
// Self-test engine for a 2-input gate: steps through all four input vectors, samples the gate
// after a settle time and compares against TRUTH_TABLE. Optional macro: GATE_CHECK_STOP_ON_FAIL_EN.
module gate_response_checker #(
  parameter logic [3:0]  TRUTH_TABLE   = 4'b1110,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       dut_out,
  output logic       stim_a,
  output logic       stim_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_mask
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
  localparam logic STOP_ON_FAIL = 1'b1;
`else
  localparam logic STOP_ON_FAIL = 1'b0;
`endif

  state_t     state_r;
  logic [1:0] vec_r;
  logic [3:0] cnt_r;
  logic       mismatch_s;
  logic [2:0] err_next_s;
  logic [1:0] vec_next_s;

  // Gate comparison is only meaningful during the single SAMPLE cycle.
  always_comb begin
    mismatch_s = 1'b0;
    err_next_s = err_count + 3'd1;
    vec_next_s = vec_r + 2'd1;
    if (state_r == SAMPLE) begin
      mismatch_s = (dut_out != TRUTH_TABLE[vec_r]);
    end else begin
      mismatch_s = 1'b0;
    end
  end

  // Sequencer: all outputs are registered here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= IDLE;
      vec_r     <= 2'd0;
      cnt_r     <= 4'd0;
      stim_a    <= 1'b0;
      stim_b    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 3'd0;
      fail_mask <= 4'd0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            state_r   <= SETTLE;
            vec_r     <= 2'd0;
            cnt_r     <= SETTLE_LOAD;
            stim_a    <= 1'b0;
            stim_b    <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 3'd0;
            fail_mask <= 4'd0;
          end
        end
        SETTLE: begin
          cnt_r <= cnt_r - 4'd1;
          if (cnt_r == 4'd1) begin
            state_r <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (mismatch_s) begin
            fail_mask[vec_r] <= 1'b1;
            err_count        <= err_next_s;
          end
          // In stop-on-fail builds stim stays on the failing vector.
          if ((vec_r == 2'd3) || (STOP_ON_FAIL && mismatch_s)) begin
            state_r <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (err_count == 3'd0) && !mismatch_s;
          end else begin
            state_r <= SETTLE;
            vec_r   <= vec_next_s;
            stim_a  <= vec_next_s[1];
            stim_b  <= vec_next_s[0];
            cnt_r   <= SETTLE_LOAD;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_response_checker.sv
// Randomised self-checking bench for gate_response_checker; expected outputs come from a
// vector-count model of the run (mismatch set = gate table XOR expected table).
module tb_gate_response_checker;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] start_v;
  logic [1:0] sa, sb, busy_v, done_v, pass_v, dout;
  logic [2:0] err0, err1;
  logic [3:0] fm0, fm1;
  logic [3:0] gate0, gate1;
  logic [11:0] obs0, obs1;
  int total = 0;
  int bad = 0;

`ifdef GATE_CHECK_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  always #5 clock = ~clock;

  // Combinational gates under test, each described by its own truth table.
  assign dout[0] = gate0[{sa[0], sb[0]}];
  assign dout[1] = gate1[{sa[1], sb[1]}];
  assign obs0 = {sa[0], sb[0], busy_v[0], done_v[0], pass_v[0], err0, fm0};
  assign obs1 = {sa[1], sb[1], busy_v[1], done_v[1], pass_v[1], err1, fm1};

  gate_response_checker dut0 (
    .clock(clock), .reset(reset), .start(start_v[0]), .dut_out(dout[0]),
    .stim_a(sa[0]), .stim_b(sb[0]), .busy(busy_v[0]), .done(done_v[0]),
    .pass(pass_v[0]), .err_count(err0), .fail_mask(fm0)
  );

  gate_response_checker #(.TRUTH_TABLE(4'b1000), .SETTLE_CYCLES(1)) dut1 (
    .clock(clock), .reset(reset), .start(start_v[1]), .dut_out(dout[1]),
    .stim_a(sa[1]), .stim_b(sb[1]), .busy(busy_v[1]), .done(done_v[1]),
    .pass(pass_v[1]), .err_count(err1), .fail_mask(fm1)
  );

  task automatic test_reset();
    reset   = 1'b1;
    start_v = 2'b11;
    repeat (2) @(negedge clock);
    total++;
    if (obs0 !== 12'd0) begin
      bad++;
      $display("FAIL reset_dut0 got=%h want=000", obs0);
    end
    total++;
    if (obs1 !== 12'd0) begin
      bad++;
      $display("FAIL reset_dut1 got=%h want=000", obs1);
    end
    reset   = 1'b0;
    start_v = 2'b00;
    @(negedge clock);
  endtask

  // One run on checker d with gate table g; extra starts land on edges E0+x1 / E0+x2,
  // and a nonzero rst_at asserts reset so it is sampled at E0+rst_at.
  task automatic run_check(input int d, input logic [3:0] g, input int x1, input int x2,
                           input int rst_at, input string name);
    int s1, klast, tdone, c, vec_e;
    logic [3:0] tt, diff, mask_e;
    logic [11:0] exp_v, got;
    s1 = (d == 0) ? 3 : 2;
    tt = (d == 0) ? 4'b1110 : 4'b1000;
    if (d == 0) gate0 = g; else gate1 = g;
    diff  = g ^ tt;
    klast = 3;
    if (STOP && diff != 4'd0) begin
      for (int k = 3; k >= 0; k--) if (diff[k]) klast = k;
      diff = 4'b0001 << klast;
    end
    tdone = (klast + 1) * s1;
    @(negedge clock);
    start_v[d] = 1'b1;
    for (int j = 0; j <= tdone + 3; j++) begin
      @(negedge clock);
      start_v[d] = 1'b0;
      got = (d == 0) ? obs0 : obs1;
      if (rst_at > 0 && j == rst_at) begin
        total++;
        if (got !== 12'd0) begin
          bad++;
          $display("FAIL %s reset_midrun j=%0d got=%h want=000", name, j, got);
        end
        reset = 1'b0;
        return;
      end
      c = j / s1;
      if (c > klast + 1) c = klast + 1;
      mask_e = diff & 4'((1 << c) - 1);
      vec_e  = (j < tdone) ? j / s1 : klast;
      exp_v  = {2'(vec_e), 1'(j < tdone), 1'(j >= tdone), 1'((j >= tdone) && (mask_e == 4'd0)),
                3'($countones(mask_e)), mask_e};
      total++;
      if (got !== exp_v) begin
        bad++;
        $display("FAIL %s d=%0d j=%0d {stim,busy,done,pass,err,mask} got=%b want=%b",
                 name, d, j, got, exp_v);
      end
      if (j + 1 == x1 || j + 1 == x2) start_v[d] = 1'b1;
      if (j + 1 == rst_at) reset = 1'b1;
    end
  endtask

  task automatic test_or();
    run_check(0, 4'b1110, 0, 0, 0, "or_gate");
  endtask

  task automatic test_stuck0();
    run_check(0, 4'b0000, 0, 0, 0, "stuck0");
  endtask

  task automatic test_and();
    run_check(0, 4'b1000, 0, 0, 0, "and_vs_or");
    run_check(1, 4'b1000, 0, 0, 0, "and_vs_and_s1");
  endtask

  task automatic test_reset_midrun();
    run_check(0, 4'b1110, 0, 0, 5, "midrun");
    run_check(0, 4'b0110, 0, 0, 0, "after_reset");
  endtask

  task automatic test_extra_start();
    run_check(0, 4'b1110, 2, 8, 0, "extra_start");
  endtask

  task automatic test_back_to_back();
    run_check(1, 4'b0000, 0, 0, 0, "b2b_a");
    run_check(1, 4'b1110, 0, 0, 0, "b2b_b");
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      run_check(int'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 0, 0, 0, "random");
    end
  endtask

  initial begin
    reset   = 1'b1;
    start_v = 2'b00;
    gate0   = 4'd0;
    gate1   = 4'd0;
    test_reset();
    test_or();
    test_stuck0();
    test_and();
    test_reset_midrun();
    test_extra_start();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
